// File: rtl/filter_buffer_p.sv
// Coefficient buffer: packs memory words into a load bank, snapshots it into a shadow, streams one element per rd_en.
// Latency: full rises on the edge accepting the last word; rd_data/rd_valid/last are registered one edge after rd_en.
// Backpressure: wr_en is ignored while full=1; the drain pauses whenever rd_en is low. Optional macro: FILTER_BUF_REPLAY_EN.
module filter_buffer_p #(
  parameter int ELEM_W         = 8,
  parameter int ELEMS_PER_WORD = 4,
  parameter int DEPTH          = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [ELEM_W*ELEMS_PER_WORD-1:0] wr_data,
  output logic                             full,
  input  logic                             rd_en,
  output logic [ELEM_W-1:0]                rd_data,
  output logic                             rd_valid,
  output logic                             last,
  output logic                             busy
);

  localparam int WORD_W = ELEM_W * ELEMS_PER_WORD;
  localparam int WORDS  = DEPTH / ELEMS_PER_WORD;
  localparam int BANK_W = ELEM_W * DEPTH;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int RCNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [BANK_W-1:0]            bank_q, bank_d;
  logic [DEPTH-1:0][ELEM_W-1:0] shadow_q, shadow_d;
  logic [WCNT_W-1:0]            wcnt_q, wcnt_d;
  logic [RCNT_W-1:0]            rcnt_q, rcnt_d;
  logic [ELEM_W-1:0]            rd_data_q, rd_data_d;
  logic                         rd_valid_q, rd_valid_d;
  logic                         last_q, last_d;

  logic                         full_int;
  logic                         snap;
  logic                         replay;
  logic [RCNT_W-1:0]            elem_idx;

`ifdef FILTER_BUF_REPLAY_EN
  logic replay_q, replay_d;
`endif

  // Element 0 sits in the top slot of the shadow, so stream index maps downwards.
  assign elem_idx = RCNT_W'(DEPTH - 1) - rcnt_q;
  assign full_int = (wcnt_q == WCNT_W'(WORDS));
  assign snap     = (state_q == IDLE) && rd_en && full_int;

`ifdef FILTER_BUF_REPLAY_EN
  // Replay only when no fresh set is waiting; a full bank always wins.
  assign replay = (state_q == IDLE) && rd_en && !full_int && replay_q;
`else
  assign replay = 1'b0;
`endif

  // Next-state for load bank, shadow, counters and the read FSM.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    shadow_d   = shadow_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    last_d     = 1'b0;
`ifdef FILTER_BUF_REPLAY_EN
    replay_d   = replay_q | snap;
`endif

    // Load side: a write can only land while the bank still has room; this
    // also drops a write coinciding with a snapshot since full=1 that cycle.
    if (wr_en && !full_int) begin
      bank_d = (bank_q << WORD_W) | BANK_W'(wr_data);
      wcnt_d = wcnt_q + WCNT_W'(1);
    end

    if (snap) begin
      shadow_d = bank_q;
      wcnt_d   = '0;
    end

    // Read side: start of a set (snapshot or replay) emits element 0 directly.
    if (snap || replay) begin
      rd_valid_d = 1'b1;
      rd_data_d  = snap ? bank_q[BANK_W-1 -: ELEM_W] : shadow_q[DEPTH-1];
      if (DEPTH == 1) begin
        last_d  = 1'b1;
        rcnt_d  = '0;
        state_d = IDLE;
      end else begin
        rcnt_d  = RCNT_W'(1);
        state_d = DRAIN;
      end
    end else if ((state_q == DRAIN) && rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d  = shadow_q[elem_idx];
      if (rcnt_q == RCNT_W'(DEPTH - 1)) begin
        last_d  = 1'b1;
        rcnt_d  = '0;
        state_d = IDLE;
      end else begin
        rcnt_d  = rcnt_q + RCNT_W'(1);
      end
    end
  end

  // Read FSM state register; clr behaves like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load bank, shadow and both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q   <= '0;
      shadow_q <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
    end else if (clr) begin
      bank_q   <= '0;
      shadow_q <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      bank_q   <= bank_d;
      shadow_q <= shadow_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // Registered read outputs; rd_data holds between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      last_q     <= 1'b0;
    end else if (clr) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      last_q     <= last_d;
    end
  end

`ifdef FILTER_BUF_REPLAY_EN
  // Replay-valid flag: set by the first snapshot, cleared only by reset/clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_q <= 1'b0;
    end else if (clr) begin
      replay_q <= 1'b0;
    end else begin
      replay_q <= replay_d;
    end
  end
`endif

  assign full     = full_int;
  assign busy     = (state_q == DRAIN);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign last     = last_q;

endmodule

// File: tb/tb_filter_buffer_p.sv
// Directed bench for filter_buffer_p: cycle vectors with expected outputs, plus async reset mid-drain.
// Latency: each vector is driven at negedge and checked 1 time unit after the following posedge.
// Backpressure: exercises dropped writes when full and drain pauses when rd_en is low.
module tb_filter_buffer_p;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        last;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    logic        clr;
    logic        wr;
    logic [31:0] wd;
    logic        rd;
    logic        full;
    logic        busy;
    logic        vld;
    logic        last;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[$];

  filter_buffer_p #(
    .ELEM_W(8),
    .ELEMS_PER_WORD(4),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .last(last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_a(input int i);
    return 32'h00010203 + 32'(i) * 32'h04040404;
  endfunction

  function automatic logic [31:0] word_b(input int i);
    return 32'h10111213 + 32'(i) * 32'h04040404;
  endfunction

  task automatic add(input logic c, input logic w, input logic [31:0] wd, input logic r,
                     input logic f, input logic b, input logic v, input logic l,
                     input logic [7:0] d);
    vec_t x;
    x.clr = c; x.wr = w; x.wd = wd; x.rd = r;
    x.full = f; x.busy = b; x.vld = v; x.last = l; x.data = d;
    tbl.push_back(x);
  endtask

  task automatic step(input logic c, input logic w, input logic [31:0] wd, input logic r);
    @(negedge clk);
    clr = c; wr_en = w; wr_data = wd; rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got full=%b busy=%b vld=%b last=%b data=%h exp full=%b busy=%b vld=%b last=%b data=%h",
               name, got[11], got[10], got[9], got[8], got[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

    // ---------------- build vector table ----------------
    // Empty read: nothing loaded, nothing emitted.
    add(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    // Fill set A; full on the 4th write.
    for (int i = 0; i < 4; i++) add(0, 1, word_a(i), 0, i == 3, 0, 0, 0, 8'h00);
    // Overflow write is dropped.
    add(0, 1, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 8'h00);
    // Drain with a one-cycle pause after element 7.
    for (int e = 0; e < 16; e++) begin
      add(0, 0, 0, 1, 0, e != 15, 1, e == 15, 8'(e));
      if (e == 7) add(0, 0, 0, 0, 0, 1, 0, 0, 8'h07);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'h0F);
    // Overlap: load A, then refill B while A drains; the write at the snapshot is dropped.
    for (int i = 0; i < 4; i++) add(0, 1, word_a(i), 0, i == 3, 0, 0, 0, 8'h0F);
    for (int k = 0; k < 32; k++) begin
      logic        w;
      logic [31:0] wd;
      w  = (k <= 4);
      wd = (k == 0) ? 32'hDEAD_BEEF : ((k <= 4) ? word_b(k - 1) : 32'h0);
      add(0, w, wd, 1, (k >= 4) && (k <= 15), !(k == 15 || k == 31), 1,
          (k == 15) || (k == 31), 8'(k));
    end
    // clr mid-drain wins over simultaneous write and read.
    for (int i = 0; i < 4; i++) add(0, 1, word_a(i), 0, i == 3, 0, 0, 0, 8'h1F);
    add(0, 0, 0, 1, 0, 1, 1, 0, 8'h00);
    add(0, 0, 0, 1, 0, 1, 1, 0, 8'h01);
    add(1, 1, 32'h1234_5678, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    // Fresh set after clr, drained from element 0.
    for (int i = 0; i < 4; i++) add(0, 1, word_a(i), 0, i == 3, 0, 0, 0, 8'h00);
    for (int e = 0; e < 16; e++) add(0, 0, 0, 1, 0, e != 15, 1, e == 15, 8'(e));
`ifdef FILTER_BUF_REPLAY_EN
    // Replay of the retained set, then a new set takes priority.
    for (int e = 0; e < 16; e++) add(0, 0, 0, 1, 0, e != 15, 1, e == 15, 8'(e));
    for (int i = 0; i < 4; i++) add(0, 1, word_b(i), 0, i == 3, 0, 0, 0, 8'h0F);
    for (int e = 0; e < 16; e++) add(0, 0, 0, 1, 0, e != 15, 1, e == 15, 8'(16 + e));
`else
    // Read with an empty bank after a drain emits nothing.
    add(0, 0, 0, 1, 0, 0, 0, 0, 8'h0F);
    add(0, 0, 0, 1, 0, 0, 0, 0, 8'h0F);
`endif

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    #1;
    check("in_reset", {full, busy, rd_valid, last, rd_data}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset", {full, busy, rd_valid, last, rd_data}, 12'h000);

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      step(tbl[i].clr, tbl[i].wr, tbl[i].wd, tbl[i].rd);
      check($sformatf("vec%0d", i), {full, busy, rd_valid, last, rd_data},
            {tbl[i].full, tbl[i].busy, tbl[i].vld, tbl[i].last, tbl[i].data});
    end
    step(0, 0, 0, 0);

    // ---------------- async reset mid-drain ----------------
    for (int i = 0; i < 4; i++) step(0, 1, word_a(i), 0);
    for (int e = 0; e < 5; e++) step(0, 0, 0, 1);
    check("pre_rst_elem4", {full, busy, rd_valid, last, rd_data}, {4'b0110, 8'h04});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {full, busy, rd_valid, last, rd_data}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1);
    check("rd_after_rst", {full, busy, rd_valid, last, rd_data}, 12'h000);
    step(0, 0, 0, 1);
    check("rd_after_rst2", {full, busy, rd_valid, last, rd_data}, 12'h000);
    for (int i = 0; i < 4; i++) step(0, 1, word_b(i), 0);
    check("refill_full", {full, busy, rd_valid, last, rd_data}, {4'b1000, 8'h00});
    step(0, 0, 0, 1);
    check("refill_elem0", {full, busy, rd_valid, last, rd_data}, {4'b0110, 8'h10});
    step(0, 0, 0, 1);
    check("refill_elem1", {full, busy, rd_valid, last, rd_data}, {4'b0110, 8'h11});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_buffer_p.md
# filter_buffer_p

Parametrised filter-coefficient buffer for the convolution datapath. It collects wide words from memory, then streams them out one element per read strobe to the MAC stage. The snapshot shadow register is separate from the load bank, so the next coefficient set can be loaded while the current one is draining. It sits between the memory read port and the filter multiplier input.

## Interface
- ELEM_W, 8, bits per element (filter tap).
- ELEMS_PER_WORD, 4, elements per write word; write width = ELEM_W*ELEMS_PER_WORD.
- DEPTH, 16, elements per coefficient set; must be a multiple of ELEMS_PER_WORD (WORDS = DEPTH/ELEMS_PER_WORD ≥ 1).
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, same effect as reset; priority over all other inputs.
- wr_en  in  1  write strobe; accepted only when full=0.
- wr_data  in  ELEM_W*ELEMS_PER_WORD  write word; most significant element is the earliest in stream order.
- full  out  1  load bank holds WORDS words.
- rd_en  in  1  read strobe.
- rd_data  out  ELEM_W  registered output element.
- rd_valid  out  1  rd_data is valid this cycle.
- last  out  1  rd_data is the final element of the set; qualified by rd_valid.
- busy  out  1  drain in progress.

## Operation
- Load side:
  - Word counter wcnt runs 0..WORDS.
  - An accepted write shifts the bank left by one word (new word in the LSBs) and increments wcnt.
  - full = (wcnt == WORDS).
  - wr_en while full=1 is dropped with no state change.
- Read side FSM states: IDLE (busy=0) and DRAIN (busy=1). Element counter rcnt runs 0..DEPTH-1.
- IDLE, rd_en, full=1 (snapshot):
  - Copy the bank to the shadow register and clear wcnt to 0.
  - Output element 0 (bank MSBs); rcnt=1.
  - Go to DRAIN, or stay IDLE if DEPTH==1, with last=1.
- IDLE, rd_en, full=0: see Configuration.
- DRAIN, rd_en:
  - Output shadow element rcnt; increment rcnt.
  - On element DEPTH-1: last=1, return to IDLE.
- DRAIN, no rd_en: hold; rd_valid=0, rd_data keeps its last value.
- Writes are legal during DRAIN: the bank refills independently while the shadow drains.
- Simultaneous wr_en and snapshot rd_en: the write is dropped, because full=1 that cycle.
- Reset/clr, including mid-drain:
  - full=0, busy=0, rd_valid=0, last=0, rd_data=0.
  - wcnt=0, rcnt=0, bank and shadow all zero, replay-valid flag cleared.
  - A partial drain is abandoned and no further elements are emitted.

## Timing
- Write latency: full rises at the edge that accepts the WORDS-th write.
- Read latency: 1 cycle. rd_data, rd_valid and last update at the edge sampling rd_en.
- Snapshot edge: full falls to 0 and busy rises to 1 at the same edge.
- Final element edge: busy falls at the same edge that presents the final element with last=1.
- Back-to-back sets are gapless: if full=1 in the cycle after the last element, the next rd_en snapshots immediately.
- A continuous rd_en yields DEPTH consecutive rd_valid cycles per set.
- rd_valid and last are single-cycle pulses per accepted read.

## Configuration
- FILTER_BUF_REPLAY_EN defined:
  - The shadow is retained after a drain; a replay-valid flag is set by the first snapshot.
  - IDLE, rd_en, full=0, flag=1: re-drain the retained shadow from element 0, with the same timing as a snapshot.
  - wcnt is untouched.
  - full=1 always takes priority over replay, using the new set.
- Not defined:
  - IDLE, rd_en, full=0 is ignored; rd_valid stays 0.
  - No flag register is present.

## Test plan
Defaults for all scenarios: ELEM_W=8, ELEMS_PER_WORD=4, DEPTH=16.
- Fill and drain: write 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F -> full=1 after the 4th write; 16 rd_en pulses -> rd_data 0x00..0x0F; last=1 only with 0x0F; busy=0 after.
- Overflow: a 5th write of 0xFFFFFFFF while full -> ignored; the drain still yields 0x00..0x0F.
- Overlap: snapshot set A, write set B (0x10..0x1F) during the drain -> full=1 before A ends; continuous rd_en -> 32 consecutive valid elements 0x00..0x1F, with last at 0x0F and 0x1F.
- Reset mid-drain: assert rst_n=0 asynchronously after 5 elements -> all outputs 0 immediately; a subsequent rd_en with full=0 -> no rd_valid (macro off).
- Empty read: rd_en with nothing loaded -> rd_valid stays 0 and busy stays 0 in both builds.
- Replay (macro on): after draining 0x00..0x0F, rd_en with full=0 -> 0x00..0x0F again. With a new set loaded instead -> the new set streams, not the replay.
